cpu4_alu_dec: RTL and testbench
===============================

// Module: cpu4_alu_dec
// PURPOSE
// - Driver side of the cpu4 ALU interface: decodes the instruction, registers operands, drives
//   alu_a/alu_b/alu_control, and captures the ALU's alu_y/alu_zero for the next stage.
// - Sits between register read and writeback/branch resolve.
// - Valid/ready handshake on both sides.
// - 2-entry buffer (main + skid); throughput 1 op/clk.
// PARAMETERS
// - DW    32  operand/result width (imm16 sign-extended to DW).
// - SKID  1   1: skid register, in_ready registered; 0: no skid, in_ready = !main_v | out_ready.
// PORTS
// - clk               in   1   clock, rising edge.
// - resetn            in   1   asynchronous, active-low reset.
// - in_valid          in   1   upstream op valid.
// - in_ready          out  1   block can accept op this cycle.
// - in_instr          in   32  instruction word.
// - in_rs_val         in   DW  rs operand.
// - in_rt_val         in   DW  rt operand.
// - alu_a             out  DW  ALU operand a (main reg).
// - alu_b             out  DW  ALU operand b (main reg).
// - alu_control       out  3   010 add, 110 sub, 000 none.
// - alu_y             in   DW  ALU result (combinational return).
// - alu_zero          in   1   ALU zero flag.
// - out_valid         out  1   result valid.
// - out_ready         in   1   downstream accepts.
// - out_result        out  DW  = alu_y.
// - out_branch_taken  out  1   beq & alu_zero.
// - out_illegal       out  1   undecodable op (feature-dependent).
// BEHAVIOUR
// - Decode (op = instr[31:26], fn = instr[5:0]); b = sext(instr[15:0]) unless noted:
//   - op 000000 fn 100000 add -> 010, b = rt.
//   - op 000000 fn 100010 sub -> 110, b = rt.
//   - op 100011 lw, op 101011 sw, op 001000 addi -> 010.
//   - op 000100 beq -> 110, b = rt; out_branch_taken = alu_zero.
//   - Anything else -> illegal, control 000.
//   - a = rs for all ops.
// - Transfers:
//   - accept = in_valid & in_ready.
//   - drain = out_valid & out_ready.
// - Latency: op accepted at edge N is presented (out_valid = 1) from cycle N+1.
// - The ALU path is combinational: out_result / out_branch_taken are valid in the same cycle as out_valid.
// - Main register loading:
//   - Main empty, or draining with skid empty: accept loads main.
//   - Main full and not draining: accept loads skid; in_ready drops next cycle.
//   - Drain with skid full: skid moves to main; in_ready rises next cycle.
// - in_ready = !skid_v (SKID = 1). Independent of in_valid and out_ready (registered).
// - While out_valid & !out_ready: alu_a, alu_b, alu_control, out_* held stable.
// - Simultaneous accept + drain with 1 entry held: occupancy is unchanged, no bubble.
// - When out_valid = 0: alu_control = 000, out_branch_taken = 0, out_illegal = 0.
// - Reset (async, any cycle, including mid-transfer):
//   - main_v = skid_v = 0; all data regs cleared; buffered ops discarded.
//   - Outputs: out_valid 0, in_ready 1, alu_a 0, alu_b 0, alu_control 000,
//     out_result follows alu_y, out_branch_taken 0, out_illegal 0.
// CONFIGURATION
// - Macro: CPU4_ALU_DEC_ILLEGAL_TRAP_EN.
// - Defined: illegal op is presented as a normal entry with out_illegal = 1, control 000,
//   out_result = alu_y (0 from ALU), out_branch_taken = 0.
// - Undefined: illegal op is accepted but not stored (silently dropped, no out_valid);
//   out_illegal is tied to 0.
// TESTING
// - add rs=5, rt=7, out_ready=1 -> next cycle:
//   out_valid 1, alu_control 010, out_result 12, branch_taken 0.
// - beq rs=rt=0x1234 -> alu_control 110, out_result 0, out_branch_taken 1.
//   - rt=0x1235 instead -> out_branch_taken 0.
// - addi rs=3, imm=0xFFFF -> b = 0xFFFFFFFF, out_result 2.
// - out_ready=0, issue 3 ops back-to-back:
//   - first two accepted; in_ready 0 from cycle after the second.
//   - op1 held stable; raise out_ready -> op1, op2, op3 drain in order, no loss or duplication.
// - Illegal op 0x3F:
//   - TRAP_EN: out_valid 1, out_illegal 1, control 000.
//   - Macro off: no out_valid; the following add is presented next.
// - resetn low while both entries full -> out_valid 0, in_ready 1 immediately; next op has 1-cycle latency.

Source files
------------

// File: rtl/cpu4_alu_dec.sv
// ============================================================================
// Module  : cpu4_alu_dec
// Purpose : Decodes the cpu4 instruction, drives the ALU from a main/skid
//           operand buffer and hands alu_y/alu_zero to the next stage.
//           Optional macro CPU4_ALU_DEC_ILLEGAL_TRAP_EN: illegal ops are
//           presented with out_illegal = 1 instead of being dropped.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu4_alu_dec #(
  parameter int DW   = 32,
  parameter int SKID = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [DW-1:0] in_rs_val,
  input  logic [DW-1:0] in_rt_val,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_control,
  input  logic [DW-1:0] alu_y,
  input  logic          alu_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_branch_taken,
  output logic          out_illegal
);

  // Entry layout: {a, b, control, is_beq}
  localparam int c_EW = 2*DW + 4;

  localparam logic [2:0] c_CTL_NONE = 3'b000;
  localparam logic [2:0] c_CTL_ADD  = 3'b010;
  localparam logic [2:0] c_CTL_SUB  = 3'b110;

  logic [5:0]      w_op;
  logic [5:0]      w_fn;
  logic [DW-1:0]   w_imm;
  logic [DW-1:0]   w_b;
  logic [2:0]      w_ctrl;
  logic            w_beq;
  logic            w_legal;
  logic            w_accept;
  logic            w_store;
  logic            w_drain;
  logic            w_ld_main_new;
  logic            w_ld_main_skid;
  logic            w_ld_skid;
  logic [c_EW-1:0] w_new;
  logic            w_unused_instr;

  logic            r_main_v;
  logic            r_skid_v;
  logic [c_EW-1:0] r_main;
  logic [c_EW-1:0] r_skid;

  assign w_op           = in_instr[31:26];
  assign w_fn           = in_instr[5:0];
  assign w_imm          = {{(DW-16){in_instr[15]}}, in_instr[15:0]};
  assign w_unused_instr = ^in_instr[25:16];

  always_comb begin
    w_ctrl  = c_CTL_NONE;
    w_b     = w_imm;
    w_beq   = 1'b0;
    w_legal = 1'b0;
    case (w_op)
      6'b000000: begin
        if (w_fn == 6'b100000) begin
          w_ctrl  = c_CTL_ADD;
          w_b     = in_rt_val;
          w_legal = 1'b1;
        end else if (w_fn == 6'b100010) begin
          w_ctrl  = c_CTL_SUB;
          w_b     = in_rt_val;
          w_legal = 1'b1;
        end
      end
      6'b100011, 6'b101011, 6'b001000: begin
        w_ctrl  = c_CTL_ADD;
        w_legal = 1'b1;
      end
      6'b000100: begin
        w_ctrl  = c_CTL_SUB;
        w_b     = in_rt_val;
        w_beq   = 1'b1;
        w_legal = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_new    = {in_rs_val, w_b, w_ctrl, w_beq};
  assign w_accept = in_valid & in_ready;
  assign w_drain  = r_main_v & out_ready;

`ifdef CPU4_ALU_DEC_ILLEGAL_TRAP_EN
  logic r_main_ill;
  logic r_skid_ill;

  assign w_store     = w_accept;
  assign out_illegal = r_main_v & r_main_ill;
`else
  assign w_store     = w_accept & w_legal;
  assign out_illegal = 1'b0;
`endif

  // Skid only ever fills while main is held; it always empties into main.
  assign w_ld_main_skid = w_drain & r_skid_v;
  assign w_ld_main_new  = w_store & (~r_main_v | w_drain);
  assign w_ld_skid      = w_store & r_main_v & ~w_drain;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else begin
      if (w_ld_main_skid) begin
        r_main <= r_skid;
      end else if (w_ld_main_new) begin
        r_main <= w_new;
      end
      if (w_ld_skid) begin
        r_skid <= w_new;
      end
      if (w_ld_main_skid | w_ld_main_new) begin
        r_main_v <= 1'b1;
      end else if (w_drain) begin
        r_main_v <= 1'b0;
      end
      if (w_ld_skid) begin
        r_skid_v <= 1'b1;
      end else if (w_ld_main_skid) begin
        r_skid_v <= 1'b0;
      end
    end
  end

`ifdef CPU4_ALU_DEC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main_ill <= 1'b0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_ld_main_skid) begin
        r_main_ill <= r_skid_ill;
      end else if (w_ld_main_new) begin
        r_main_ill <= ~w_legal;
      end
      if (w_ld_skid) begin
        r_skid_ill <= ~w_legal;
      end
    end
  end
`endif

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~r_skid_v;
    end else begin : g_noskid
      assign in_ready = ~r_main_v | out_ready;
    end
  endgenerate

  assign alu_a            = r_main[c_EW-1 -: DW];
  assign alu_b            = r_main[DW+3 : 4];
  assign alu_control      = r_main_v ? r_main[3:1] : c_CTL_NONE;
  assign out_valid        = r_main_v;
  assign out_result       = alu_y;
  assign out_branch_taken = r_main_v & r_main[0] & alu_zero;

endmodule

`default_nettype wire

// File: tb/tb_cpu4_alu_dec.sv
// ============================================================================
// Module  : tb_cpu4_alu_dec
// Purpose : Self-checking bench for cpu4_alu_dec with a behavioural ALU and
//           a queue-based reference of the two-entry operand buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu4_alu_dec;

`ifdef CPU4_ALU_DEC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_branch_taken;
  logic        out_illegal;

  cpu4_alu_dec #(.DW(32), .SKID(1)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .in_rs_val        (in_rs_val),
    .in_rt_val        (in_rt_val),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_control      (alu_control),
    .alu_y            (alu_y),
    .alu_zero         (alu_zero),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_branch_taken (out_branch_taken),
    .out_illegal      (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU on the far side of the interface
  always_comb begin
    case (alu_control)
      3'b010:  alu_y = alu_a + alu_b;
      3'b110:  alu_y = alu_a - alu_b;
      default: alu_y = 32'h0;
    endcase
  end
  assign alu_zero = (alu_y == 32'h0);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [2:0]  ctrl;
    logic        br;
    logic        ill;
    logic        legal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  ctrl;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_op(input logic [31:0] instr, input logic [31:0] rs,
                                  input logic [31:0] rt);
    exp_t        e;
    logic [31:0] imm;
    int          op;
    int          fn;
    imm     = {{16{instr[15]}}, instr[15:0]};
    op      = int'(instr[31:26]);
    fn      = int'(instr[5:0]);
    e.a     = rs;
    e.b     = imm;
    e.res   = 32'h0;
    e.ctrl  = 3'b000;
    e.br    = 1'b0;
    e.ill   = 1'b1;
    e.legal = 1'b0;
    if (op == 0 && fn == 32) begin
      e.b = rt; e.ctrl = 3'b010; e.res = rs + rt; e.legal = 1'b1;
    end else if (op == 0 && fn == 34) begin
      e.b = rt; e.ctrl = 3'b110; e.res = rs - rt; e.legal = 1'b1;
    end else if (op == 35 || op == 43 || op == 8) begin
      e.ctrl = 3'b010; e.res = rs + imm; e.legal = 1'b1;
    end else if (op == 4) begin
      e.b = rt; e.ctrl = 3'b110; e.res = rs - rt; e.br = (rs == rt); e.legal = 1'b1;
    end
    if (e.legal) e.ill = 1'b0;
    return e;
  endfunction

  task automatic check_model();
    exp_t h;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      h = q[0];
      chk("alu_a", alu_a, h.a);
      chk("alu_b", alu_b, h.b);
      chk("alu_control", alu_control, h.ctrl);
      chk("out_result", out_result, h.res);
      chk("out_branch_taken", out_branch_taken, h.br);
      chk("out_illegal", out_illegal, h.ill);
    end else begin
      chk("idle_control", alu_control, 3'b000);
      chk("idle_branch", out_branch_taken, 1'b0);
      chk("idle_illegal", out_illegal, 1'b0);
    end
  endtask

  // Drive one cycle of inputs, advance the reference, then check after the edge
  task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] rs,
                      input logic [31:0] rt, input logic ordy);
    exp_t e;
    bit   drn;
    in_valid  = v;
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
    out_ready = ordy;
    last_acc  = v && (q.size() < 2);
    drn       = (q.size() > 0) && ordy;
    e         = ref_op(instr, rs, rt);
    if (drn) void'(q.pop_front());
    if (last_acc && (e.legal || TRAP)) q.push_back(e);
    @(posedge clk);
    #1;
    check_model();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: begin w[31:26] = 6'd0;  w[5:0] = 6'd32; end
      1: begin w[31:26] = 6'd0;  w[5:0] = 6'd34; end
      2: w[31:26] = 6'd35;
      3: w[31:26] = 6'd43;
      4: w[31:26] = 6'd8;
      5: w[31:26] = 6'd4;
      6: w[31:26] = 6'h3F;
      default: begin w[31:26] = 6'd0; w[5:0] = 6'h2A; end
    endcase
    return w;
  endfunction

  vec_t vt[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rs;
    logic [31:0] rt;

    vt[0] = '{32'h0085_3020, 32'd5,        32'd7,        3'b010, 32'd7,        32'd12,       1'b0};
    vt[1] = '{32'h1085_0003, 32'h1234,     32'h1234,     3'b110, 32'h1234,     32'd0,        1'b1};
    vt[2] = '{32'h1085_0003, 32'h1234,     32'h1235,     3'b110, 32'h1235,     32'hFFFFFFFF, 1'b0};
    vt[3] = '{32'h2085_FFFF, 32'd3,        32'd99,       3'b010, 32'hFFFFFFFF, 32'd2,        1'b0};
    vt[4] = '{32'h0085_3022, 32'd10,       32'd3,        3'b110, 32'd3,        32'd7,        1'b0};
    vt[5] = '{32'h8C85_0010, 32'h100,      32'd5,        3'b010, 32'h10,       32'h110,      1'b0};
    vt[6] = '{32'hAC85_FFFC, 32'h100,      32'd5,        3'b010, 32'hFFFFFFFC, 32'hFC,       1'b0};
    vt[7] = '{32'h0085_3022, 32'd3,        32'd10,       3'b110, 32'd10,       32'hFFFFFFF9, 1'b0};

    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_rs_val = 32'h0;
    in_rt_val = 32'h0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_control", alu_control, 3'b000);
    chk("rst_branch", out_branch_taken, 1'b0);
    chk("rst_illegal", out_illegal, 1'b0);
    chk("rst_result", out_result, alu_y);
    resetn = 1'b1;

    // Directed vectors, one op per cycle with downstream always ready
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vt[i].instr, vt[i].rs, vt[i].rt, 1'b1);
      chk("vec_valid", out_valid, 1'b1);
      chk("vec_control", alu_control, vt[i].ctrl);
      chk("vec_alu_b", alu_b, vt[i].b);
      chk("vec_result", out_result, vt[i].res);
      chk("vec_branch", out_branch_taken, vt[i].br);
    end
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Back-pressure: three ops back to back into a stalled output
    step(1'b1, 32'h0000_0020, 32'd1, 32'd1, 1'b0);
    step(1'b1, 32'h0000_0020, 32'd2, 32'd2, 1'b0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    step(1'b1, 32'h0000_0020, 32'd3, 32'd3, 1'b0);
    chk("bp_op3_refused", last_acc, 1'b0);
    chk("bp_hold_a", alu_a, 32'd1);
    step(1'b1, 32'h0000_0020, 32'd3, 32'd3, 1'b0);
    chk("bp_hold_result", out_result, 32'd2);
    step(1'b1, 32'h0000_0020, 32'd3, 32'd3, 1'b1);
    chk("bp_second_a", alu_a, 32'd2);
    chk("bp_ready_back", in_ready, 1'b1);
    step(1'b1, 32'h0000_0020, 32'd3, 32'd3, 1'b1);
    chk("bp_third_a", alu_a, 32'd3);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("bp_empty", out_valid, 1'b0);

    // Illegal opcode followed by a legal add
    step(1'b1, 32'hFC00_0000, 32'd9, 32'd9, 1'b1);
    chk("ill_valid", out_valid, TRAP);
    chk("ill_flag", out_illegal, TRAP);
    chk("ill_control", alu_control, 3'b000);
    step(1'b1, 32'h0000_0020, 32'd2, 32'd2, 1'b1);
    chk("ill_next_add", alu_control, 3'b010);
    chk("ill_next_result", out_result, 32'd4);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Asynchronous reset while both entries are full
    step(1'b1, 32'h0000_0020, 32'd11, 32'd1, 1'b0);
    step(1'b1, 32'h0000_0020, 32'd12, 32'd1, 1'b0);
    chk("full_in_ready", in_ready, 1'b0);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_alu_a", alu_a, 32'h0);
    chk("arst_control", alu_control, 3'b000);
    q.delete();
    #2;
    resetn = 1'b1;
    step(1'b1, 32'h0000_0020, 32'd5, 32'd7, 1'b1);
    chk("post_rst_valid", out_valid, 1'b1);
    chk("post_rst_result", out_result, 32'd12);
    step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

    // Randomised traffic against the queue reference
    for (int i = 0; i < 1500; i++) begin
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? rs : $urandom;
      step(($urandom_range(0, 9) < 7), rand_instr(), rs, rt, ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    end
    chk("final_empty", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
